// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard controller.
//   - Forwarding mux select codes (operand A / operand B muxes).
//   - Stage-entry record tracked for every in-flight instruction.
// The rd field is sized for the widest supported register specifier; narrower
// specifiers are zero-extended when stored and when compared.
package fwd_hazard_ctrl_pkg;

  localparam int unsigned RD_MAX_W = 8;

  localparam logic [1:0] SEL_RF    = 2'b00;  // register-file read data
  localparam logic [1:0] SEL_EXMEM = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] SEL_MEMWB = 2'b10;  // MEM/WB result (ALU or load)
  localparam logic [1:0] SEL_WBBYP = 2'b11;  // value written the previous cycle

  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                regwrite;
    logic                memread;
  } stage_entry_t;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request / forwarding-select bundle for fwd_hazard_ctrl.
//   master : pipeline side, drives the ID-stage instruction fields and the
//            freeze / flush controls, receives the selects and stall request.
//   slave  : the hazard controller.
interface fwd_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  id_use_rs;
  logic                  id_use_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_regwrite;
  logic                  id_memread;
  logic                  pipe_freeze;
  logic                  flush;
  logic [1:0]            fwd_sel_a;
  logic [1:0]            fwd_sel_b;
  logic                  stall_out;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_regwrite, id_memread, pipe_freeze, flush,
    input  fwd_sel_a, fwd_sel_b, stall_out
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_rd,
           id_regwrite, id_memread, pipe_freeze, flush,
    output fwd_sel_a, fwd_sel_b, stall_out
  );
endinterface

// File: rtl/fwd_hazard_ctrl_match.sv
// fwd_match: combinational producer search for one source operand.
//   src_i/use_i      : source specifier and whether the instruction reads it
//   ex_i/mem_i/wb_i  : tracked entries of the three nearest producers
//   sel_o            : forwarding select, nearest matching producer wins
//   load_haz_o       : the EX producer matches and is a load (load-use hazard)
module fwd_match
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W         = 5,
  parameter int ZERO_REG_HARDWIRED = 1,
  parameter int WB_WRITE_THROUGH   = 0
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic                  use_i,
  input  stage_entry_t          ex_i,
  input  stage_entry_t          mem_i,
  input  stage_entry_t          wb_i,
  output logic [1:0]            sel_o,
  output logic                  load_haz_o
);

  logic [RD_MAX_W-1:0] src_ext;
  logic                src_live;
  logic                ex_hit;
  logic                mem_hit;
  logic                wb_hit;
  logic                unused_memread;

  assign src_ext  = RD_MAX_W'(src_i);
  assign src_live = use_i && !((ZERO_REG_HARDWIRED != 0) && (src_i == '0));

  assign ex_hit  = src_live && ex_i.valid  && ex_i.regwrite  && (ex_i.rd  == src_ext);
  assign mem_hit = src_live && mem_i.valid && mem_i.regwrite && (mem_i.rd == src_ext);
  assign wb_hit  = src_live && wb_i.valid  && wb_i.regwrite  && (wb_i.rd  == src_ext);

  // Only the EX producer can cause a load-use stall.
  assign unused_memread = mem_i.memread ^ wb_i.memread;

  always_comb begin
    sel_o = SEL_RF;
    if (ex_hit) begin
      sel_o = SEL_EXMEM;
    end else if (mem_hit) begin
      sel_o = SEL_MEMWB;
    end else if (wb_hit) begin
      sel_o = (WB_WRITE_THROUGH != 0) ? SEL_RF : SEL_WBBYP;
    end
  end

  assign load_haz_o = ex_hit && ex_i.memread;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand-forwarding select generation and load-use stall
// detection for the EX stage.
//   clk, rst_n : pipeline clock, asynchronous active-low reset
//   bus        : slave side of fwd_hazard_ctrl_if
//                (id_* fields, pipe_freeze, flush in; fwd_sel_a/b, stall_out out)
// Tracks {valid, rd, regwrite, memread} for the instructions in EX, MEM, WB and
// one stage past WB. Selects are registered: they are computed for the
// instruction in ID and become visible while it occupies EX.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W         = 5,
  parameter int ZERO_REG_HARDWIRED = 1,
  parameter int WB_WRITE_THROUGH   = 0
) (
  input logic              clk,
  input logic              rst_n,
  fwd_hazard_ctrl_if.slave bus
);

  stage_entry_t ex_q,  ex_d;
  stage_entry_t mem_q, mem_d;
  stage_entry_t wb_q,  wb_d;
  stage_entry_t wb2_q, wb2_d;
  logic [1:0]   sel_a_q, sel_a_d;
  logic [1:0]   sel_b_q, sel_b_d;

  logic [1:0]   sel_a_c, sel_b_c;
  logic         haz_a, haz_b;
  logic         stall;
  logic         accept;

  fwd_match #(
    .REG_ADDR_W        (REG_ADDR_W),
    .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED),
    .WB_WRITE_THROUGH  (WB_WRITE_THROUGH)
  ) u_match_a (
    .src_i     (bus.id_rs),
    .use_i     (bus.id_use_rs),
    .ex_i      (ex_q),
    .mem_i     (mem_q),
    .wb_i      (wb_q),
    .sel_o     (sel_a_c),
    .load_haz_o(haz_a)
  );

  fwd_match #(
    .REG_ADDR_W        (REG_ADDR_W),
    .ZERO_REG_HARDWIRED(ZERO_REG_HARDWIRED),
    .WB_WRITE_THROUGH  (WB_WRITE_THROUGH)
  ) u_match_b (
    .src_i     (bus.id_rt),
    .use_i     (bus.id_use_rt),
    .ex_i      (ex_q),
    .mem_i     (mem_q),
    .wb_i      (wb_q),
    .sel_o     (sel_b_c),
    .load_haz_o(haz_b)
  );

  // Flush and freeze both suppress the stall: a flushed consumer is killed
  // anyway, and a frozen pipeline moves nothing.
  assign stall  = bus.id_valid && (haz_a || haz_b) && !bus.flush && !bus.pipe_freeze;
  assign accept = bus.id_valid && !bus.flush && !stall;

  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    wb2_d   = wb2_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (!bus.pipe_freeze) begin
      wb2_d = wb_q;
      wb_d  = mem_q;
      mem_d = ex_q;
      if (accept) begin
        ex_d.valid    = 1'b1;
        ex_d.rd       = RD_MAX_W'(bus.id_rd);
        ex_d.regwrite = bus.id_regwrite;
        ex_d.memread  = bus.id_memread;
        sel_a_d       = sel_a_c;
        sel_b_d       = sel_b_c;
      end else begin
        ex_d    = '0;
        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      wb2_q   <= '0;
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      wb2_q   <= wb2_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign bus.fwd_sel_a = sel_a_q;
  assign bus.fwd_sel_b = sel_b_q;
  assign bus.stall_out = stall;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios plus a random
// stream, all checked against an instruction-history reference model.
module tb_fwd_hazard_ctrl;

  localparam int W   = 5;
  localparam bit ZR  = 1'b1;
  localparam bit WBT = 1'b0;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  fwd_hazard_ctrl_if #(.REG_ADDR_W(W)) bus ();

  fwd_hazard_ctrl #(
    .REG_ADDR_W        (W),
    .ZERO_REG_HARDWIRED(int'(ZR)),
    .WB_WRITE_THROUGH  (int'(WBT))
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit v; int rs; bit urs; int rt; bit urt; int rd; bit rw; bit ld; bit fz; bit fl;
  } in_t;

  typedef struct { bit v; int rd; bit rw; bit ld; } instr_t;

  // hist[0] = instruction currently in EX, hist[1] = MEM, hist[2] = WB, hist[3] = past WB
  instr_t     hist[4];
  logic [1:0] m_sel_a, m_sel_b;

  function automatic in_t alu(int rd, int rs, int rt);
    in_t i = '{1, rs, 1, rt, 1, rd, 1, 0, 0, 0};
    return i;
  endfunction

  function automatic in_t load(int rd, int rs);
    in_t i = '{1, rs, 1, 0, 0, rd, 1, 1, 0, 0};
    return i;
  endfunction

  function automatic in_t nop();
    in_t i = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    return i;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) hist[k] = '{0, 0, 0, 0};
    m_sel_a = 2'b00;
    m_sel_b = 2'b00;
  endfunction

  // Distance 0/1/2 back from the consumer -> EX/MEM, MEM/WB, WB bypass.
  function automatic logic [1:0] ref_sel(int src, bit u);
    if (!u || (ZR && src == 0)) return 2'b00;
    for (int d = 0; d < 3; d++) begin
      if (hist[d].v && hist[d].rw && hist[d].rd == src) begin
        case (d)
          0:       return 2'b01;
          1:       return 2'b10;
          default: return WBT ? 2'b00 : 2'b11;
        endcase
      end
    end
    return 2'b00;
  endfunction

  function automatic bit ref_stall(in_t i);
    bit hit_rs, hit_rt;
    if (!i.v || i.fl || i.fz) return 0;
    if (!(hist[0].v && hist[0].rw && hist[0].ld)) return 0;
    hit_rs = i.urs && !(ZR && i.rs == 0) && hist[0].rd == i.rs;
    hit_rt = i.urt && !(ZR && i.rt == 0) && hist[0].rd == i.rt;
    return hit_rs || hit_rt;
  endfunction

  function automatic void model_tick(in_t i, bit st);
    logic [1:0] sa, sb;
    bit acc;
    if (i.fz) return;
    sa  = ref_sel(i.rs, i.urs);
    sb  = ref_sel(i.rt, i.urt);
    acc = i.v && !i.fl && !st;
    for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = acc ? '{1, i.rd, i.rw, i.ld} : '{0, 0, 0, 0};
    m_sel_a = acc ? sa : 2'b00;
    m_sel_b = acc ? sb : 2'b00;
  endfunction

  // Presents one ID instruction, samples the combinational stall before the
  // edge, advances DUT and model by one edge and returns #1 after it.
  task automatic drive_cycle(input in_t i, output logic act_stall, output bit exp_stall);
    bus.id_valid    = i.v;
    bus.id_rs       = W'(i.rs);
    bus.id_use_rs   = i.urs;
    bus.id_rt       = W'(i.rt);
    bus.id_use_rt   = i.urt;
    bus.id_rd       = W'(i.rd);
    bus.id_regwrite = i.rw;
    bus.id_memread  = i.ld;
    bus.pipe_freeze = i.fz;
    bus.flush       = i.fl;
    #2;
    act_stall = bus.stall_out;
    exp_stall = ref_stall(i);
    @(posedge clk);
    model_tick(i, exp_stall);
    #1;
  endtask

  task automatic test_reset();
    logic s; bit es;
    rst_n = 1'b0;
    drive_cycle(nop(), s, es);
    drive_cycle(nop(), s, es);
    n_tests++;
    if (bus.fwd_sel_a !== 2'b00) begin n_fail++; $display("FAIL reset_sel_a: got %b want 00", bus.fwd_sel_a); end
    n_tests++;
    if (bus.fwd_sel_b !== 2'b00) begin n_fail++; $display("FAIL reset_sel_b: got %b want 00", bus.fwd_sel_b); end
    n_tests++;
    if (bus.stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall_out); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_back_to_back();
    logic s; bit es;
    // distance 1 -> 01 on A
    drive_cycle(alu(3, 1, 2), s, es);
    drive_cycle(alu(4, 3, 2), s, es);
    n_tests++;
    if (bus.fwd_sel_a !== m_sel_a || m_sel_a !== 2'b01) begin n_fail++; $display("FAIL b2b_d1_a: got %b want 01", bus.fwd_sel_a); end
    n_tests++;
    if (bus.fwd_sel_b !== 2'b00) begin n_fail++; $display("FAIL b2b_d1_b: got %b want 00", bus.fwd_sel_b); end
    // distance 2 -> 10
    drive_cycle(alu(11, 1, 2), s, es);
    drive_cycle(alu(20, 21, 22), s, es);
    drive_cycle(alu(4, 11, 2), s, es);
    n_tests++;
    if (bus.fwd_sel_a !== m_sel_a || m_sel_a !== 2'b10) begin n_fail++; $display("FAIL b2b_d2_a: got %b want 10", bus.fwd_sel_a); end
    // distance 3 -> WB bypass (11, or 00 with write-through)
    drive_cycle(alu(12, 1, 2), s, es);
    drive_cycle(alu(20, 21, 22), s, es);
    drive_cycle(alu(23, 21, 22), s, es);
    drive_cycle(alu(4, 2, 12), s, es);
    n_tests++;
    if (bus.fwd_sel_b !== m_sel_b || m_sel_b !== (WBT ? 2'b00 : 2'b11)) begin n_fail++; $display("FAIL b2b_d3_b: got %b want %b", bus.fwd_sel_b, m_sel_b); end
  endtask

  task automatic test_load_use();
    logic s; bit es;
    drive_cycle(load(7, 1), s, es);
    drive_cycle(alu(8, 1, 7), s, es);
    n_tests++;
    if (s !== 1'b1 || es !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", s); end
    n_tests++;
    if (bus.fwd_sel_b !== 2'b00) begin n_fail++; $display("FAIL lu_bubble_b: got %b want 00", bus.fwd_sel_b); end
    drive_cycle(alu(8, 1, 7), s, es);
    n_tests++;
    if (s !== 1'b0) begin n_fail++; $display("FAIL lu_stall_once: got %b want 0", s); end
    n_tests++;
    if (bus.fwd_sel_b !== m_sel_b || m_sel_b !== 2'b10) begin n_fail++; $display("FAIL lu_sel_b: got %b want 10", bus.fwd_sel_b); end
  endtask

  task automatic test_priority();
    logic s; bit es;
    drive_cycle(alu(9, 1, 2), s, es);
    drive_cycle(alu(9, 3, 4), s, es);
    drive_cycle(alu(10, 9, 9), s, es);
    n_tests++;
    if (bus.fwd_sel_a !== 2'b01) begin n_fail++; $display("FAIL prio_a: got %b want 01", bus.fwd_sel_a); end
    n_tests++;
    if (bus.fwd_sel_b !== 2'b01) begin n_fail++; $display("FAIL prio_b: got %b want 01", bus.fwd_sel_b); end
  endtask

  task automatic test_zero_reg();
    logic s; bit es;
    drive_cycle(alu(0, 1, 2), s, es);
    drive_cycle(alu(1, 0, 0), s, es);
    n_tests++;
    if (bus.fwd_sel_a !== m_sel_a || bus.fwd_sel_b !== m_sel_b) begin n_fail++; $display("FAIL zero_sel: got %b/%b want %b/%b", bus.fwd_sel_a, bus.fwd_sel_b, m_sel_a, m_sel_b); end
    drive_cycle(load(0, 1), s, es);
    drive_cycle(alu(2, 0, 0), s, es);
    n_tests++;
    if (s !== es) begin n_fail++; $display("FAIL zero_no_stall: got %b want %b", s, es); end
  endtask

  task automatic test_freeze_flush();
    logic s; bit es; in_t i;
    drive_cycle(alu(3, 1, 2), s, es);
    drive_cycle(alu(5, 3, 2), s, es);
    i = load(6, 5);
    i.fz = 1;
    for (int unsigned c = 0; c < 3; c++) begin
      drive_cycle(i, s, es);
      n_tests++;
      if (bus.fwd_sel_a !== m_sel_a || m_sel_a !== 2'b01 || s !== 1'b0) begin
        n_fail++; $display("FAIL freeze_hold_%0d: got sel %b stall %b want 01/0", c, bus.fwd_sel_a, s);
      end
    end
    i.fz = 0;
    drive_cycle(i, s, es);
    n_tests++;
    if (bus.fwd_sel_a !== m_sel_a || m_sel_a !== 2'b01) begin n_fail++; $display("FAIL freeze_release: got %b want 01", bus.fwd_sel_a); end
    // load in EX now; flushed consumer must not stall
    i = alu(7, 6, 6);
    i.fl = 1;
    drive_cycle(i, s, es);
    n_tests++;
    if (s !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", s); end
    n_tests++;
    if (bus.fwd_sel_a !== 2'b00 || bus.fwd_sel_b !== 2'b00) begin n_fail++; $display("FAIL flush_bubble: got %b/%b want 00/00", bus.fwd_sel_a, bus.fwd_sel_b); end
    drive_cycle(alu(7, 6, 1), s, es);
    n_tests++;
    if (s !== 1'b0 || bus.fwd_sel_a !== m_sel_a || m_sel_a !== 2'b10) begin n_fail++; $display("FAIL flush_after: got %b stall %b want 10/0", bus.fwd_sel_a, s); end
  endtask

  task automatic test_reset_mid();
    logic s; bit es;
    drive_cycle(alu(5, 1, 2), s, es);
    drive_cycle(load(5, 5), s, es);
    bus.id_valid  = 1; bus.id_rs = 5; bus.id_use_rs = 1;
    bus.pipe_freeze = 0; bus.flush = 0;
    #1;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.fwd_sel_a !== 2'b00 || bus.stall_out !== 1'b0) begin n_fail++; $display("FAIL reset_mid: got %b stall %b want 00/0", bus.fwd_sel_a, bus.stall_out); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive_cycle(alu(6, 5, 5), s, es);
    n_tests++;
    if (bus.fwd_sel_a !== 2'b00 || bus.fwd_sel_b !== 2'b00) begin n_fail++; $display("FAIL reset_first: got %b/%b want 00/00", bus.fwd_sel_a, bus.fwd_sel_b); end
  endtask

  task automatic test_random();
    logic s; bit es; in_t i;
    for (int unsigned c = 0; c < 400; c++) begin
      i.v   = ($urandom_range(0, 9) < 8);
      i.rs  = int'($urandom_range(0, 7));
      i.rt  = int'($urandom_range(0, 7));
      i.rd  = int'($urandom_range(0, 7));
      i.urs = ($urandom_range(0, 9) < 8);
      i.urt = ($urandom_range(0, 9) < 6);
      i.rw  = ($urandom_range(0, 9) < 8);
      i.ld  = ($urandom_range(0, 9) < 3);
      i.fz  = ($urandom_range(0, 9) == 0);
      i.fl  = ($urandom_range(0, 9) == 0);
      drive_cycle(i, s, es);
      n_tests++;
      if (s !== es) begin n_fail++; $display("FAIL rand_stall[%0d]: got %b want %b", c, s, es); end
      n_tests++;
      if (bus.fwd_sel_a !== m_sel_a) begin n_fail++; $display("FAIL rand_sel_a[%0d]: got %b want %b", c, bus.fwd_sel_a, m_sel_a); end
      n_tests++;
      if (bus.fwd_sel_b !== m_sel_b) begin n_fail++; $display("FAIL rand_sel_b[%0d]: got %b want %b", c, bus.fwd_sel_b, m_sel_b); end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    model_reset();
    #1;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_priority();
    test_zero_reg();
    test_freeze_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Drives the 2-bit select inputs of the two 32-bit 4:1 operand-forwarding muxes in the EX stage (operand A, operand B).
- Tracks the destination register of every in-flight instruction in EX, MEM, WB and one cycle past WB.
- Produces registered forwarding selects for the instruction entering EX.
- Detects load-use hazards and requests a one-cycle stall with bubble insertion.

Parameters:
REG_ADDR_W, 5, register-specifier width
ZERO_REG_HARDWIRED, 1, when 1 register 0 is never forwarded and never causes a stall
WB_WRITE_THROUGH, 0, when 1 the register file returns same-cycle write data, so a WB-stage producer yields select 00 instead of 11

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_ADDR_W  source A specifier
id_rt  in  REG_ADDR_W  source B specifier
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_rd  in  REG_ADDR_W  destination specifier
id_regwrite  in  1  instruction writes rd
id_memread  in  1  instruction is a load
pipe_freeze  in  1  whole-pipeline freeze (memory wait)
flush  in  1  kill instruction moving ID->EX (branch taken)
fwd_sel_a  out  2  select for operand-A mux
fwd_sel_b  out  2  select for operand-B mux
stall_out  out  1  hold PC and IF/ID, bubble into EX

Behaviour:
- Select encoding: 00 register-file data; 01 EX/MEM ALU result; 10 MEM/WB result (ALU or load data); 11 WB-bypass register (value written the previous cycle).
- Tracking state: four stage entries EX, MEM, WB, WB2, each {valid, rd, regwrite, memread}.
- Reset (rst_n low, asynchronous): all entry valids 0; fwd_sel_a/b = 00; stall_out = 0.
- A producer matches a source when all hold:
  - entry valid and regwrite;
  - rd equals the source;
  - the source's use bit is 1;
  - not (ZERO_REG_HARDWIRED and source == 0).
- stall_out is combinational, same cycle:
  - asserted when id_valid, the EX entry matches rs or rt, and the EX entry has memread;
  - forced 0 while flush or pipe_freeze is high.
- Each rising edge with pipe_freeze = 0:
  - WB2 <= WB; WB <= MEM; MEM <= EX.
  - EX <= ID fields when id_valid & !flush & !stall_out; otherwise EX <= bubble (valid 0).
  - fwd_sel_x <= select computed from the pre-edge EX/MEM/WB entries: EX match -> 01; else MEM match -> 10; else WB match -> 11, or 00 if WB_WRITE_THROUGH; else 00.
  - Priority is nearest producer first.
  - fwd_sel_a/b <= 00 when the EX entry receives a bubble (flush, stall, or !id_valid).
- pipe_freeze = 1: all entries and both selects hold; stall_out = 0.
- Simultaneous flush and load-use: flush wins; bubble inserted, stall_out = 0.
- Load-use resolution: the stall cycle inserts a bubble. Next cycle the load sits in MEM, the consumer is re-presented, and the consumer's select becomes 10.
- Latency: selects valid in the cycle the consumer occupies EX, one edge after it leaves ID.
- Reset mid-operation clears all tracking; the first instruction after reset sees select 00.

Decomposition:
- Shared package: select-code constants (SEL_RF, SEL_EXMEM, SEL_MEMWB, SEL_WBBYP) and the stage-entry struct {valid, rd, regwrite, memread}.
- One sub-module is natural: fwd_match, combinational, instantiated twice. Inputs: one source specifier, its use bit, EX/MEM/WB entries. Outputs: 2-bit select and load-hazard flag.

Test Plan:
- Reset: hold rst_n = 0 mid-stream with valid entries -> selects 00, stall_out 0 immediately; after release, an instruction reading r5 gets select 00.
- Back-to-back ALU: add r3 then sub r4,r3,r2 -> consumer in EX has fwd_sel_a = 01, fwd_sel_b = 00; with 1 and 2 unrelated instructions between -> 10, then 11 (00 when WB_WRITE_THROUGH = 1).
- Load-use: lw r7 then add r8,r1,r7 -> stall_out = 1 for exactly one cycle, bubble in EX (selects 00); next cycle consumer gets fwd_sel_b = 10.
- Priority: add r9; add r9; or r10,r9,r9 -> both selects 01, from the nearest producer.
- Zero register: add r0 then add r1,r0,r0 -> selects 00; lw r0 then use of r0 -> no stall.
- Freeze and flush: pipe_freeze high 3 cycles during a dependency chain -> selects and entries unchanged, stall_out 0. flush coincident with a load-use -> stall_out 0, EX gets a bubble, selects 00.
